// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and types for the pipelined multiplier
// Purpose: default operand width, pipeline latency and product type used by
//          multiplier_8bit and its partial-product adder.
// Ports:   none (package).

package mult_pkg;

  localparam int MULT_WIDTH   = 8;
  localparam int MULT_LATENCY = 3;

  typedef logic [2*MULT_WIDTH-1:0] prod_t;

  // Number of stage-2 partial sums for a given operand width: pairs of
  // partial products, plus one pass-through slot when the width is odd.
  function automatic int num_sums(input int width);
    return (width + 1) / 2;
  endfunction

endpackage

// File: rtl/mult_pp_adder.sv
// rtl/mult_pp_adder.sv - combinational adder for one pair of shifted partial products
// Purpose: sums two already-shifted partial products in full product width.
// Ports:
//   pp_a_i  in   2*WIDTH  first shifted partial product
//   pp_b_i  in   2*WIDTH  second shifted partial product
//   sum_o   out  2*WIDTH  pp_a_i + pp_b_i (never overflows for legal operands)

module mult_pp_adder #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] pp_a_i,
  input  logic [2*WIDTH-1:0] pp_b_i,
  output logic [2*WIDTH-1:0] sum_o
);

  assign sum_o = pp_a_i + pp_b_i;

endmodule

// File: rtl/multiplier_8bit.sv
// rtl/multiplier_8bit.sv - three-stage pipelined unsigned multiplier
// Purpose: product = A * B at full 2*WIDTH width, one operand pair per clock,
//          result and out_valid three cycles after the pair is presented.
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset, clears all stages
//   in_valid   in   1        A/B qualify this cycle
//   A          in   WIDTH    multiplicand, unsigned
//   B          in   WIDTH    multiplier, unsigned
//   out_valid  out  1        product holds a valid result this cycle
//   product    out  2*WIDTH  A*B of the pair presented three cycles earlier

module multiplier_8bit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW    = 2 * WIDTH;
  localparam int NPAIR = WIDTH / 2;
  localparam int NSUM  = num_sums(WIDTH);

  // Valid travels alongside the data; bit k is the valid of stage k+1.
  logic [MULT_LATENCY-1:0] vld_q;
  logic [MULT_LATENCY-1:0] vld_d;

  // Stage 1: operand registers
  logic [WIDTH-1:0] a_q, b_q;

  // Stage 2: shifted partial products and pairwise sums
  logic [PW-1:0] pp    [WIDTH];
  logic [PW-1:0] sum_d [NSUM];
  logic [PW-1:0] sum_q [NSUM];

  // Stage 3: final reduction
  logic [PW-1:0] product_d;
  logic [PW-1:0] product_q;

  assign vld_d = {vld_q[MULT_LATENCY-2:0], in_valid};

  // Datapath is deliberately not gated by valid; bubbles carry whatever
  // arithmetic result their operands produce and are qualified downstream.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = '0;
      if (b_q[i]) begin
        pp[i] = PW'(a_q) << i;
      end
    end
  end

  for (genvar p = 0; p < NPAIR; p++) begin : g_pair
    mult_pp_adder #(
      .WIDTH (WIDTH)
    ) u_pp_adder (
      .pp_a_i (pp[2*p]),
      .pp_b_i (pp[2*p+1]),
      .sum_o  (sum_d[p])
    );
  end

  if ((WIDTH % 2) != 0) begin : g_odd
    assign sum_d[NSUM-1] = pp[WIDTH-1];
  end

  always_comb begin
    product_d = '0;
    for (int j = 0; j < NSUM; j++) begin
      product_d = product_d + sum_q[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
      for (int j = 0; j < NSUM; j++) begin
        sum_q[j] <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      a_q       <= A;
      b_q       <= B;
      product_q <= product_d;
      for (int j = 0; j < NSUM; j++) begin
        sum_q[j] <= sum_d[j];
      end
    end
  end

  assign out_valid = vld_q[MULT_LATENCY-1];
  assign product   = product_q;

endmodule

// File: tb/tb_multiplier_8bit.sv
// tb/tb_multiplier_8bit.sv - scoreboard bench for multiplier_8bit

module tb_multiplier_8bit;
  import mult_pkg::*;

  typedef struct {
    prod_t p;
    int    cyc;
    int    tag;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic       out_valid;
  prod_t      product;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;
  int   sweep_seen;

  logic [7:0] s_a [10] = '{8'd12, 8'd200, 8'd17, 8'd99, 8'd250, 8'd31, 8'd64, 8'd7, 8'd100, 8'd255};
  logic [7:0] s_b [10] = '{8'd13, 8'd3, 8'd15, 8'd99, 8'd4, 8'd33, 8'd64, 8'd143, 8'd250, 8'd128};
  prod_t      s_p [10] = '{16'd156, 16'd600, 16'd255, 16'd9801, 16'd1000,
                           16'd1023, 16'd4096, 16'd1001, 16'd25000, 16'd32640};

  multiplier_8bit #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Present one pair for the coming edge and return just after that edge.
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic push, input prod_t p, input int tag);
    in_valid = v;
    A        = a;
    B        = b;
    if (v && push) exp_q.push_back('{p: p, cyc: cyc, tag: tag});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'h00, 1'b0, '0, 0);
  endtask

  // Monitor: every presented output is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_product", int'(product), 0);
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("product", int'(product), int'(e.p));
        chk("latency", cyc - e.cyc, MULT_LATENCY);
        if (e.tag == 6) sweep_seen++;
      end
    end else if (exp_q.size() > 0 && cyc >= exp_q[0].cyc + MULT_LATENCY) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("missing_out_valid", 0, 1);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    sweep_seen = 0;

    // 1. Reset held with a live pair on the inputs, released between edges.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    A        = 8'd5;
    B        = 8'd7;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b1;
    exp_q.push_back('{p: 16'd35, cyc: cyc, tag: 1});
    @(posedge clk);
    #1;

    // 2. Corners
    drive(1'b1, 8'd0,   8'd200, 1'b1, 16'd0,     2);
    drive(1'b1, 8'd1,   8'd173, 1'b1, 16'd173,   2);
    drive(1'b1, 8'd254, 8'd254, 1'b1, 16'd64516, 2);
    drive(1'b1, 8'd255, 8'd255, 1'b1, 16'd65025, 2);
    drive(1'b1, 8'd128, 8'd2,   1'b1, 16'd256,   2);
    drive(1'b1, 8'd200, 8'd0,   1'b1, 16'd0,     2);
    drive(1'b1, 8'd173, 8'd1,   1'b1, 16'd173,   2);

    // 3. Back-to-back stream
    for (int i = 0; i < 10; i++) drive(1'b1, s_a[i], s_b[i], 1'b1, s_p[i], 3);

    // 4. Bubbles: valid 1,0,1,1,0
    drive(1'b1, 8'd3,   8'd4,   1'b1, 16'd12,  4);
    drive(1'b0, 8'hxx,  8'hxx,  1'b1, 16'd0,   4);
    drive(1'b1, 8'd10,  8'd10,  1'b1, 16'd100, 4);
    drive(1'b1, 8'd255, 8'd1,   1'b1, 16'd255, 4);
    drive(1'b0, 8'hxx,  8'hxx,  1'b1, 16'd0,   4);
    idle(4);
    chk("drain_before_midreset", exp_q.size(), 0);

    // 5. Three pairs in flight, then an asynchronous reset pulse between edges.
    drive(1'b1, 8'd9,  8'd9,  1'b0, '0, 5);
    drive(1'b1, 8'd11, 8'd11, 1'b0, '0, 5);
    drive(1'b1, 8'd13, 8'd13, 1'b0, '0, 5);
    in_valid = 1'b0;
    chk("midreset_pre_valid", int'(out_valid), 1);
    chk("midreset_pre_product", int'(product), 81);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid_drop", int'(out_valid), 0);
    chk("midreset_product_clear", int'(product), 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(5);

    // 6. Exhaustive sweep
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        drive(1'b1, a[7:0], b[7:0], 1'b1, prod_t'(a * b), 6);
      end
    end
    idle(5);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("sweep_count", sweep_seen, 65536);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
